sum_accumulator: RTL and testbench

//   Downstream stage of the 8-bit adder: consumes each {carry_out, sum} result
//   and accumulates COUNT results into a wider running total.

---
 rtl/sum_accumulator.sv | 127 ++++++++++++
 tb/tb_sum_accumulator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Accumulates COUNT {carry, sum} adder results into an ACC_WIDTH total and
// emits one total per frame over a valid/ready handshake; flush closes a frame early.
module sum_accumulator #(
  parameter  int WIDTH     = 8,
  parameter  int ACC_WIDTH = 16,
  parameter  int COUNT     = 4,
  localparam int LEN_W     = $clog2(COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 carry_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 overflow
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t               state_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q, out_valid_q, overflow_q;
  logic [ACC_WIDTH-1:0] acc_out_q;
  logic [LEN_W-1:0]     frame_len_q;

  logic                 accept_s, close_s;
  logic [ACC_WIDTH-1:0] sample_s;
  logic [ACC_WIDTH:0]   sum_ext_s;

  assign accept_s  = in_valid & in_ready_q;
  assign sample_s  = ACC_WIDTH'({carry_in, sum});
  // Extra top bit captures the carry out of the accumulator for sticky overflow.
  assign sum_ext_s = {1'b0, acc_q} + {1'b0, sample_s};

  // Next running total, count and overflow, plus the frame-close decision.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    close_s = 1'b0;
    if (accept_s) begin
      acc_d   = sum_ext_s[ACC_WIDTH-1:0];
      count_d = count_q + LEN_W'(1);
      ovf_d   = ovf_q | sum_ext_s[ACC_WIDTH];
    end else begin
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
    end
    if (state_q == ST_ACCUM) begin
      close_s = (accept_s && (count_d == LEN_W'(COUNT))) ||
                (flush && ((count_q != LEN_W'(0)) || accept_s));
    end else begin
      close_s = 1'b0;
    end
  end

  // Frame FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      frame_len_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          acc_q   <= acc_d;
          count_q <= count_d;
          ovf_q   <= ovf_d;
          if (close_s) begin
            state_q     <= ST_HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            acc_out_q   <= acc_d;
            frame_len_q <= count_d;
            overflow_q  <= ovf_d;
          end else begin
            state_q <= ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q     <= ST_ACCUM;
          acc_q       <= '0;
          count_q     <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign frame_len = frame_len_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: two accumulators (16-bit and 10-bit totals) share one
// input stream and are compared against a frame-level queue model.
module tb_sum_accumulator;

  localparam int CNT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, carry_in = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [7:0] sum = 8'h00;

  logic        in_ready_a, out_valid_a, overflow_a;
  logic [15:0] acc_out_a;
  logic [2:0]  frame_len_a;
  logic        in_ready_b, out_valid_b, overflow_b;
  logic [9:0]  acc_out_b;
  logic [2:0]  frame_len_b;

  always #5 clk = ~clk;

  sum_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(CNT)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .sum(sum), .carry_in(carry_in), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .acc_out(acc_out_a), .frame_len(frame_len_a),
    .overflow(overflow_a));

  sum_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .COUNT(CNT)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .sum(sum), .carry_in(carry_in), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .acc_out(acc_out_b), .frame_len(frame_len_b),
    .overflow(overflow_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Frame model: samples of the open frame, holding flag, last emitted results.
  int m_q[$];
  bit m_hold = 1'b0;
  int ea_acc = 0, eb_acc = 0, e_len = 0;
  bit ea_ovf = 1'b0, eb_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int total;
    if (rst) begin
      m_hold = 1'b0;
      m_q.delete();
      ea_acc = 0; eb_acc = 0; e_len = 0; ea_ovf = 1'b0; eb_ovf = 1'b0;
    end else if (!m_hold) begin
      if (in_valid) m_q.push_back(int'({carry_in, sum}));
      if ((in_valid && m_q.size() == CNT) || (flush && m_q.size() > 0)) begin
        total = 0;
        foreach (m_q[k]) total += m_q[k];
        ea_acc = total % 65536;  ea_ovf = (total >= 65536);
        eb_acc = total % 1024;   eb_ovf = (total >= 1024);
        e_len  = m_q.size();
        m_hold = 1'b1;
        m_q.delete();
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_eq("in_ready_a",  in_ready_a,  !m_hold);
    check_eq("out_valid_a", out_valid_a, m_hold);
    check_eq("in_ready_b",  in_ready_b,  !m_hold);
    check_eq("out_valid_b", out_valid_b, m_hold);
    check_eq("acc_out_a",   acc_out_a,   ea_acc);
    check_eq("acc_out_b",   acc_out_b,   eb_acc);
    check_eq("frame_len_a", frame_len_a, e_len);
    check_eq("frame_len_b", frame_len_b, e_len);
    if (m_hold) begin
      check_eq("overflow_a", overflow_a, ea_ovf);
      check_eq("overflow_b", overflow_b, eb_ovf);
    end
  endtask

  // One clock: drive inputs, advance the model, then check at the next falling edge.
  task automatic cyc(input bit v, input bit c, input bit [7:0] s, input bit f,
                     input bit ordy, input bit r);
    rst = r; in_valid = v; carry_in = c; sum = s; flush = f; out_ready = ordy;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    cyc(0, 0, 8'h00, 0, 0, 1);
    check_eq("reset_in_ready", in_ready_a, 1'b1);
    check_eq("reset_out_valid", out_valid_a, 1'b0);

    // Basic frame of four
    cyc(1, 0, 8'h30, 0, 1, 0);
    cyc(1, 0, 8'h70, 0, 1, 0);
    cyc(1, 0, 8'hB0, 0, 1, 0);
    cyc(1, 1, 8'h50, 0, 1, 0);
    check_eq("t1_valid", out_valid_a, 1'b1);
    check_eq("t1_acc", acc_out_a, 16'h02A0);
    check_eq("t1_len", frame_len_a, 3'd4);
    check_eq("t1_ovf", overflow_a, 1'b0);
    cyc(0, 0, 8'h00, 0, 1, 0);

    // Wrap in the 10-bit accumulator
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'hFF, 0, 1, 0);
    check_eq("t2_acc_b", acc_out_b, 10'h3FC);
    check_eq("t2_ovf_b", overflow_b, 1'b1);
    check_eq("t2_acc_a", acc_out_a, 16'h07FC);
    check_eq("t2_ovf_a", overflow_a, 1'b0);
    cyc(0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h01, 0, 1, 0);
    check_eq("t2b_acc_b", acc_out_b, 10'h004);
    check_eq("t2b_ovf_b", overflow_b, 1'b0);
    cyc(0, 0, 8'h00, 0, 1, 0);

    // Backpressure in HOLD with in_valid held high
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h11, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 8'h55, 1, 0, 0);
      check_eq("t3_in_ready", in_ready_a, 1'b0);
      check_eq("t3_acc_stable", acc_out_a, 16'h0044);
    end
    cyc(1, 0, 8'h55, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h02, 0, 1, 0);
    check_eq("t3_fresh_acc", acc_out_a, 16'h0008);
    cyc(0, 0, 8'h00, 0, 1, 0);

    // Flush cases
    cyc(1, 0, 8'h10, 0, 1, 0);
    cyc(1, 0, 8'h20, 0, 1, 0);
    cyc(0, 0, 8'h00, 1, 1, 0);
    check_eq("t4_acc", acc_out_a, 16'h0030);
    check_eq("t4_len", frame_len_a, 3'd2);
    cyc(0, 0, 8'h00, 0, 1, 0);
    cyc(1, 0, 8'h10, 1, 1, 0);
    check_eq("t4b_acc", acc_out_a, 16'h0010);
    check_eq("t4b_len", frame_len_a, 3'd1);
    cyc(0, 0, 8'h00, 0, 1, 0);
    cyc(0, 0, 8'h00, 1, 1, 0);
    check_eq("t4c_no_out", out_valid_a, 1'b0);
    check_eq("t4c_len_kept", frame_len_a, 3'd1);

    // Reset mid-frame and during HOLD
    cyc(1, 0, 8'h01, 0, 1, 0);
    cyc(1, 0, 8'h01, 0, 1, 0);
    cyc(1, 0, 8'h01, 1, 1, 1);
    check_eq("t5_valid", out_valid_a, 1'b0);
    check_eq("t5_ready", in_ready_a, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h07, 0, 0, 0);
    check_eq("t5_hold", out_valid_a, 1'b1);
    cyc(1, 0, 8'h01, 1, 0, 1);
    check_eq("t5b_valid", out_valid_a, 1'b0);
    check_eq("t5b_ready", in_ready_a, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h01, 0, 1, 0);
    check_eq("t5_fresh_acc", acc_out_a, 16'h0004);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 8'($urandom),
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) == 0);
    end
    cyc(0, 0, 8'h00, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
